halut_decoder: RTL and testbench

- Consumer end of the encoder output stream.
- Accepts one (c_addr, k_addr) code per valid cycle, in codebook order 0..C-1.
- For each code, reads a signed LUT entry from a local C*K memory and accumulates it into a running sum.
- After codebook C-1, emits the completed dot-product partial sum for one output column as a single-cycle pulse.
- Sits directly behind the 4-unit encoder wrapper; LUT contents are loaded through a write port.

---
 rtl/halut_decoder.sv | 79 +++++++
 tb/tb_halut_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/halut_decoder.sv
// halut_decoder: accumulates signed LUT entries over codes c=0..C-1 and pulses the column sum.
// Optional HALUT_DECODER_SATURATE_EN clamps the emitted sum to the signed DataTypeWidth range.
module halut_decoder #(
  parameter int K = 16,
  parameter int C = 32,
  parameter int DataTypeWidth = 16,
  localparam int CAddrWidth = $clog2(C),
  localparam int TreeDepth = $clog2(K),
  localparam int LutAddrWidth = $clog2(C * K),
  localparam int AccWidth = DataTypeWidth + $clog2(C)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LutAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic                     decoder_i,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     valid_i,
  output logic [AccWidth-1:0]      result_o,
  output logic                     valid_o,
  output logic                     seq_err_o
);
  logic [DataTypeWidth-1:0] lut [C*K];
  logic [DataTypeWidth-1:0] rdata;
  logic                     s1_valid, s1_first, s1_last, accept;
  logic [CAddrWidth-1:0]    exp_c;
  logic [AccWidth-1:0]      acc, sum, res;

  assign accept = valid_i && decoder_i;

  // K is a power of two, so c*K + k is just the concatenation
  always_ff @(posedge clk_i) begin
    if (we_i) lut[waddr_i] <= wdata_i;
    if (accept) rdata <= lut[{c_addr_i, k_addr_i}];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      exp_c     <= '0;
      seq_err_o <= 1'b0;
    end else begin
      s1_valid  <= accept;
      seq_err_o <= accept && (c_addr_i != exp_c);
      if (accept) begin
        s1_first <= c_addr_i == '0;
        s1_last  <= c_addr_i == CAddrWidth'(C - 1);
        exp_c    <= c_addr_i + CAddrWidth'(1);
      end
    end
  end

  assign sum = (s1_first ? '0 : acc) + {{(AccWidth-DataTypeWidth){rdata[DataTypeWidth-1]}}, rdata};

`ifdef HALUT_DECODER_SATURATE_EN
  localparam logic [AccWidth-1:0] SatMax = {{(AccWidth-DataTypeWidth+1){1'b0}}, {(DataTypeWidth-1){1'b1}}};
  localparam logic [AccWidth-1:0] SatMin = ~SatMax;
  assign res = $signed(sum) > $signed(SatMax) ? SatMax :
               $signed(sum) < $signed(SatMin) ? SatMin : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc      <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= s1_valid && s1_last;
      if (s1_valid) acc <= sum;
      if (s1_valid && s1_last) result_o <= res;
    end
  end
endmodule

// File: tb/tb_halut_decoder.sv
// tb_halut_decoder: randomized streams checked against a cycle-level behavioural model.
module tb_halut_decoder;
  localparam int K = 16, C = 32;
  logic        clk_i = 1'b0, rst_ni = 1'b0, we_i = 1'b0, decoder_i = 1'b0, valid_i = 1'b0;
  logic [8:0]  waddr_i = '0;
  logic [15:0] wdata_i = '0;
  logic [4:0]  c_addr_i = '0;
  logic [3:0]  k_addr_i = '0;
  logic [20:0] result_o;
  logic        valid_o, seq_err_o;
  int errors = 0, checks = 0;
  int lut_m [C][K];
  int m_sum = 0, m_exp = 0, held = 0, pend_val = 0, pulses = 0, errs_seen = 0;
  bit pend_v = 0;

  halut_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .decoder_i(decoder_i), .c_addr_i(c_addr_i), .k_addr_i(k_addr_i), .valid_i(valid_i),
    .result_o(result_o), .valid_o(valid_o), .seq_err_o(seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(int s);
`ifdef HALUT_DECODER_SATURATE_EN
    return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`else
    return s;
`endif
  endfunction

  // one clock: model the edge from the current inputs, then compare outputs at the falling edge
  task automatic tick();
    bit cur_v = pend_v;
    int cur_val = pend_val;
    bit se = 0;
    int c, k;
    pend_v = 0;
    if (!rst_ni) begin
      m_exp = 0;
      cur_v = 0;
      held = 0;
    end else if (valid_i && decoder_i) begin
      c = int'(c_addr_i);
      k = int'(k_addr_i);
      se = c != m_exp;
      m_exp = (c + 1) % C;
      m_sum = (c == 0 ? 0 : m_sum) + lut_m[c][k];
      if (c == C - 1) begin
        pend_v = 1;
        pend_val = clamp(m_sum);
      end
    end
    if (we_i) lut_m[int'(waddr_i) / K][int'(waddr_i) % K] = int'($signed(wdata_i));
    @(posedge clk_i);
    @(negedge clk_i);
    if (cur_v) held = cur_val;
    check("valid_o", int'(valid_o), int'(cur_v));
    check("seq_err_o", int'(seq_err_o), int'(se));
    check("result_o", int'($signed(result_o)), held);
    pulses += int'(valid_o);
    errs_seen += int'(seq_err_o);
  endtask

  task automatic wr(int c, int k, int v);
    waddr_i = 9'(c * K + k);
    wdata_i = 16'(v);
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic load(int mode);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        wr(c, k, mode == 0 ? c + 1 : mode == 1 ? 32'h7FFF : int'($urandom_range(0, 65535)));
  endtask

  task automatic send(int c, int k, bit gaps);
    if (gaps && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 3)) begin
        valid_i = 1'b0;
        tick();
      end
    c_addr_i = 5'(c);
    k_addr_i = 4'(k);
    valid_i = 1'b1;
    decoder_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic stream(int c0, int c1, int k, bit gaps);
    for (int c = c0; c <= c1; c++) send(c, k, gaps);
  endtask

  task automatic drain();
    valid_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start();
    pulses = 0;
    errs_seen = 0;
  endtask

  initial begin
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check("reset_result", int'(result_o), 0);

    load(0);
    start();
    stream(0, C - 1, 5, 0);
    drain();
    check("s1_result", int'($signed(result_o)), 528);
    check("s1_pulses", pulses, 1);
    check("s1_seq_err", errs_seen, 0);

    for (int c = 0; c < C; c++) wr(c, 3, 32'hFFFF);
    start();
    stream(0, C - 1, 3, 0);
    drain();
    check("s2_result", int'($signed(result_o)), -32);
    check("s2_result_raw", int'(result_o), 32'h1FFFE0);

    start();
    stream(0, 15, 5, 1);
    decoder_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_addr_i = 5'(16 + i);
      k_addr_i = 4'($urandom_range(0, K - 1));
      tick();
    end
    stream(16, C - 1, 5, 1);
    drain();
    check("s3_result", int'($signed(result_o)), 528);
    check("s3_pulses", pulses, 1);
    check("s3_seq_err", errs_seen, 0);

    start();
    stream(0, 9, 5, 0);
    stream(12, C - 1, 5, 0);
    drain();
    check("s4_result", int'($signed(result_o)), 505);
    check("s4_seq_err", errs_seen, 1);
    check("s4_pulses", pulses, 1);

    stream(0, 15, 5, 0);
    rst_ni = 1'b0;
    #1;
    check("async_result", int'(result_o), 0);
    check("async_valid", int'(valid_o), 0);
    check("async_seq_err", int'(seq_err_o), 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    start();
    stream(0, C - 1, 5, 0);
    drain();
    check("s5_result", int'($signed(result_o)), 528);
    check("s5_pulses", pulses, 1);

    waddr_i = 9'(5);
    wdata_i = 16'(100);
    we_i = 1'b1;
    send(0, 5, 0);
    we_i = 1'b0;
    stream(1, C - 1, 5, 0);
    drain();
    check("rw_old_result", int'($signed(result_o)), 528);
    stream(0, C - 1, 5, 0);
    drain();
    check("rw_new_result", int'($signed(result_o)), 627);

    load(1);
    stream(0, C - 1, 7, 0);
    drain();
`ifdef HALUT_DECODER_SATURATE_EN
    check("max_result", int'($signed(result_o)), 32767);
`else
    check("max_result", int'($signed(result_o)), 1048544);
`endif

    load(2);
    for (int s = 0; s < 12; s++) begin
      int c = 0;
      while (c < C) begin
        send(c, int'($urandom_range(0, K - 1)), 1);
        c += ($urandom_range(0, 9) == 0) ? 2 : 1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
